control_unit: RTL and testbench
===============================

# control_unit

Hardwired control sequencer for the bus-based 32-bit CPU datapath. It replaces the hand-driven per-test control sequences: it steps through fetch (T0–T2), decodes `ir[31:27]`, and drives every datapath control strobe for T3–T7 of each instruction, then loops back to fetch. It sits beside the datapath inside the CPU top level. Its outputs connect one-for-one to the datapath control inputs of the same name.

## Interface
Parameters:
- `MAX_T`, default 7: last step index. Fixed step encoding is 3 bits, T0–T7.

Ports:
- `clk`  in  1  single system clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-low (0 = reset), sampled on rising `clk`.
- `ir`  in  32  instruction register contents from datapath; `ir[31:27]` = opcode.
- `con_ff`  in  1  branch-condition flip-flop output.
- `stop`  in  1  pause request, honoured only at instruction boundaries.
- `run`  out  1  1 while fetching or executing; 0 in RESET, PAUSE, HALT.
- `HIout LOout Zhighout Zlowout PCout IRout MDRout INout Cout Yout MARout`  out  1 each  bus drive selects.
- `Read IncPC`  out  1 each  MDR source = memory; PC self-increment.
- `AND OR ADD SUB MUL DIV SHR SHRA SHL ROR ROL NEG NOT`  out  1 each  ALU op, at most one high.
- `Gra Grb Grc Rin Rout BAout`  out  1 each  register-select encoder controls.
- `HIin LOin PCin IRin Zin Yin MARin MDRin CONin OUT_Portin`  out  1 each  register load enables.
- `read_mem write_mem`  out  1 each  RAM strobes.
- `CON_RESET PCSave`  out  1 each  clear CON flip-flop; save PC to R15.

## Operation
- States: RESET, T0…T7, PAUSE, HALT. Outputs are a combinational decode of (state, opcode, `con_ff`). No output is registered.
- RESET: `CON_RESET`=1, every other output 0. The next state is T0.
- Fetch:
  - T0: IncPC, PCin, MARin.
  - T1: Read, read_mem, MDRin.
  - T2: Read, read_mem, MDRout, IRin.
- Opcodes:
  - ld=00000, ldi=00001, st=00010, add=00011, sub=00100, and=00101, or=00110, ror=00111, rol=01000, shr=01001, shra=01010, shl=01011.
  - addi=01100, andi=01101, ori=01110, div=01111, mul=10000, neg=10001, not=10010.
  - br=10011, jr=10100, jal=10101, in=10110, out=10111, mfhi=11000, mflo=11001, nop=11010, halt=11011.
- Execute sequences:
  - reg-reg ALU: T3 Grb Rout Yin; T4 Grc Rout op Zin; T5 Zlowout Gra Rin.
  - addi/andi/ori: T3 Grb Rout Yin; T4 Cout op(ADD/AND/OR) Zin; T5 Zlowout Gra Rin.
  - neg/not: T3 Grb Rout op Zin; T4 Zlowout Gra Rin.
  - mul/div: T3 Gra Rout Yin; T4 Grb Rout op Zin; T5 Zlowout LOin; T6 Zhighout HIin.
  - ldi: T3 Grb BAout Yin; T4 Cout ADD Zin; T5 Zlowout Gra Rin.
  - ld: ldi T3–T4; T5 Zlowout MARin; T6 Read read_mem MDRin; T7 MDRout Gra Rin.
  - st: ldi T3–T4; T5 Zlowout MARin; T6 Gra Rout MDRin; T7 write_mem.
  - br: T3 Gra Rout CONin; T4 PCout Yin; T5 Cout ADD Zin; T6 Zlowout PCin only if `con_ff`=1.
  - jr: T3 Gra Rout PCin.
  - jal: T3 PCSave; T4 Gra Rout PCin.
  - in: T3 INout Gra Rin.
  - out: T3 Gra Rout OUT_Portin.
  - mfhi/mflo: T3 HIout/LOout Gra Rin.
- nop, opcodes 11100–11111, and compiled-out opcodes: T3 with all outputs 0.
- halt: T3 then HALT. HALT holds all outputs 0 until reset.
- End of instruction: the last step goes to PAUSE if `stop`=1, else to T0. PAUSE returns to T0 in the cycle after `stop`=0.

## Timing
- One step per clock. Each instruction takes 3 fetch cycles plus 1–5 execute cycles.
  - add: 6 cycles T0–T5.
  - ld/st: 8 cycles.
  - jr: 4 cycles.
- Opcode is valid from T3 (IR loads at the end of T2). Decode must ignore `ir` during T0–T2.
- `con_ff` is sampled combinationally in T6 of br. It is valid because CONin fired in T3.
- `reset`=0 in any state forces RESET on the next edge, including mid-instruction and in HALT. Outputs follow the RESET decode from that edge.
- `stop` has no effect mid-instruction.

## Configuration
- `CTRL_MULDIV_EN` defined: mul/div sequences are generated.
- Undefined: opcodes 01111/10000 decode as nop, and MUL/DIV/HIin/LOin are tied 0.

## Structure
- Shared package `cpu_ctrl_pkg` holds:
  - opcode constants;
  - the state enum (RESET, T0–T7, PAUSE, HALT);
  - a 5-bit opcode typedef.
- Sub-module `ctrl_decode` is purely combinational: (state, opcode, `con_ff`) to strobes. `control_unit` keeps only the state register and next-state logic.

## Test plan
- Reset low 2 cycles, then high: `CON_RESET`=1 with all else 0; T0 has IncPC=PCin=MARin=1; `run`=1.
- `ir`=0x18A00000 (add R1,R2,R4): T3 Grb Rout Yin, T4 Grc Rout ADD Zin, T5 Zlowout Gra Rin; T0 on the 7th edge.
- ld (`ir`=0x00800055): read_mem high in T1, T2, T6; Gra Rin in T7; 8 cycles total.
- br with `con_ff`=0, then with `con_ff`=1: PCin absent in T6 in the first case, present in the second.
- `stop`=1 asserted during T4 of add: PAUSE after T5 with `run`=0. Releasing `stop` gives T0 one cycle later.
- halt (`ir`=0xD8000000): HALT with all outputs 0 for 10 cycles. Reset pulse returns to RESET.
- Without `CTRL_MULDIV_EN`, mul: T3 then T0 with MUL never asserted.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control sequencer: opcodes, step states, strobe bundle.
package cpu_ctrl_pkg;

  typedef logic [4:0] opcode_t;

  localparam opcode_t OP_LD   = 5'b00000;
  localparam opcode_t OP_LDI  = 5'b00001;
  localparam opcode_t OP_ST   = 5'b00010;
  localparam opcode_t OP_ADD  = 5'b00011;
  localparam opcode_t OP_SUB  = 5'b00100;
  localparam opcode_t OP_AND  = 5'b00101;
  localparam opcode_t OP_OR   = 5'b00110;
  localparam opcode_t OP_ROR  = 5'b00111;
  localparam opcode_t OP_ROL  = 5'b01000;
  localparam opcode_t OP_SHR  = 5'b01001;
  localparam opcode_t OP_SHRA = 5'b01010;
  localparam opcode_t OP_SHL  = 5'b01011;
  localparam opcode_t OP_ADDI = 5'b01100;
  localparam opcode_t OP_ANDI = 5'b01101;
  localparam opcode_t OP_ORI  = 5'b01110;
  localparam opcode_t OP_DIV  = 5'b01111;
  localparam opcode_t OP_MUL  = 5'b10000;
  localparam opcode_t OP_NEG  = 5'b10001;
  localparam opcode_t OP_NOT  = 5'b10010;
  localparam opcode_t OP_BR   = 5'b10011;
  localparam opcode_t OP_JR   = 5'b10100;
  localparam opcode_t OP_JAL  = 5'b10101;
  localparam opcode_t OP_IN   = 5'b10110;
  localparam opcode_t OP_OUT  = 5'b10111;
  localparam opcode_t OP_MFHI = 5'b11000;
  localparam opcode_t OP_MFLO = 5'b11001;
  localparam opcode_t OP_NOP  = 5'b11010;
  localparam opcode_t OP_HALT = 5'b11011;

  // Step states occupy 0..7 so the low three bits are the step index.
  typedef enum logic [3:0] {
    S_T0    = 4'd0,
    S_T1    = 4'd1,
    S_T2    = 4'd2,
    S_T3    = 4'd3,
    S_T4    = 4'd4,
    S_T5    = 4'd5,
    S_T6    = 4'd6,
    S_T7    = 4'd7,
    S_RESET = 4'd8,
    S_PAUSE = 4'd9,
    S_HALT  = 4'd10
  } state_t;

  typedef struct packed {
    logic HIout, LOout, Zhighout, Zlowout, PCout, IRout, MDRout, INout, Cout, Yout, MARout;
    logic Read, IncPC;
    logic AND, OR, ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT;
    logic Gra, Grb, Grc, Rin, Rout, BAout;
    logic HIin, LOin, PCin, IRin, Zin, Yin, MARin, MDRin, CONin, OUT_Portin;
    logic read_mem, write_mem;
    logic CON_RESET, PCSave;
  } ctrl_t;

  function automatic logic is_step(state_t s);
    return (s <= S_T7);
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational strobe decode from (state, opcode, con_ff); also flags the last step and halt.
// mul/div sequences exist only when CTRL_MULDIV_EN is defined.
module ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  state_t  i_state,
  input  opcode_t i_opcode,
  input  logic    i_con_ff,
  output ctrl_t   o_ctrl,
  output logic    o_last,
  output logic    o_halt
);

  logic w_rr, w_imm, w_unary, w_addr, w_muldiv;

  assign w_rr    = i_opcode inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL,
                                    OP_SHR, OP_SHRA, OP_SHL};
  assign w_imm   = i_opcode inside {OP_ADDI, OP_ANDI, OP_ORI};
  assign w_unary = i_opcode inside {OP_NEG, OP_NOT};
  assign w_addr  = i_opcode inside {OP_LDI, OP_LD, OP_ST};
`ifdef CTRL_MULDIV_EN
  assign w_muldiv = i_opcode inside {OP_MUL, OP_DIV};
`else
  assign w_muldiv = 1'b0;
`endif

  function automatic ctrl_t f_alu(ctrl_t c, opcode_t op);
    ctrl_t r;
    r = c;
    case (op)
      OP_ADD, OP_ADDI: r.ADD  = 1'b1;
      OP_SUB:          r.SUB  = 1'b1;
      OP_AND, OP_ANDI: r.AND  = 1'b1;
      OP_OR, OP_ORI:   r.OR   = 1'b1;
      OP_ROR:          r.ROR  = 1'b1;
      OP_ROL:          r.ROL  = 1'b1;
      OP_SHR:          r.SHR  = 1'b1;
      OP_SHRA:         r.SHRA = 1'b1;
      OP_SHL:          r.SHL  = 1'b1;
      OP_NEG:          r.NEG  = 1'b1;
      OP_NOT:          r.NOT  = 1'b1;
      OP_MUL:          r.MUL  = 1'b1;
      OP_DIV:          r.DIV  = 1'b1;
      default:         ;
    endcase
    return r;
  endfunction

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    o_ctrl = '0;
    o_last = 1'b0;
    o_halt = 1'b0;
    case (i_state)
      S_RESET: o_ctrl.CON_RESET = 1'b1;
      S_T0: begin
        o_ctrl.IncPC = 1'b1; o_ctrl.PCin = 1'b1; o_ctrl.MARin = 1'b1;
      end
      S_T1: begin
        o_ctrl.Read = 1'b1; o_ctrl.read_mem = 1'b1; o_ctrl.MDRin = 1'b1;
      end
      S_T2: begin
        o_ctrl.Read = 1'b1; o_ctrl.read_mem = 1'b1; o_ctrl.MDRout = 1'b1; o_ctrl.IRin = 1'b1;
      end
      S_T3: begin
        if (w_rr || w_imm) begin
          o_ctrl.Grb = 1'b1; o_ctrl.Rout = 1'b1; o_ctrl.Yin = 1'b1;
        end else if (w_unary) begin
          o_ctrl.Grb = 1'b1; o_ctrl.Rout = 1'b1; o_ctrl.Zin = 1'b1;
          o_ctrl = f_alu(o_ctrl, i_opcode);
        end else if (w_muldiv) begin
          o_ctrl.Gra = 1'b1; o_ctrl.Rout = 1'b1; o_ctrl.Yin = 1'b1;
        end else if (w_addr) begin
          o_ctrl.Grb = 1'b1; o_ctrl.BAout = 1'b1; o_ctrl.Yin = 1'b1;
        end else begin
          case (i_opcode)
            OP_BR:   begin o_ctrl.Gra = 1'b1; o_ctrl.Rout = 1'b1; o_ctrl.CONin = 1'b1; end
            OP_JR:   begin o_ctrl.Gra = 1'b1; o_ctrl.Rout = 1'b1; o_ctrl.PCin = 1'b1; o_last = 1'b1; end
            OP_JAL:  o_ctrl.PCSave = 1'b1;
            OP_IN:   begin o_ctrl.INout = 1'b1; o_ctrl.Gra = 1'b1; o_ctrl.Rin = 1'b1; o_last = 1'b1; end
            OP_OUT:  begin o_ctrl.Gra = 1'b1; o_ctrl.Rout = 1'b1; o_ctrl.OUT_Portin = 1'b1; o_last = 1'b1; end
            OP_MFHI: begin o_ctrl.HIout = 1'b1; o_ctrl.Gra = 1'b1; o_ctrl.Rin = 1'b1; o_last = 1'b1; end
            OP_MFLO: begin o_ctrl.LOout = 1'b1; o_ctrl.Gra = 1'b1; o_ctrl.Rin = 1'b1; o_last = 1'b1; end
            OP_HALT: o_halt = 1'b1;
            default: o_last = 1'b1;
          endcase
        end
      end
      S_T4: begin
        if (w_rr) begin
          o_ctrl.Grc = 1'b1; o_ctrl.Rout = 1'b1; o_ctrl.Zin = 1'b1;
          o_ctrl = f_alu(o_ctrl, i_opcode);
        end else if (w_imm) begin
          o_ctrl.Cout = 1'b1; o_ctrl.Zin = 1'b1;
          o_ctrl = f_alu(o_ctrl, i_opcode);
        end else if (w_unary) begin
          o_ctrl.Zlowout = 1'b1; o_ctrl.Gra = 1'b1; o_ctrl.Rin = 1'b1; o_last = 1'b1;
        end else if (w_muldiv) begin
          o_ctrl.Grb = 1'b1; o_ctrl.Rout = 1'b1; o_ctrl.Zin = 1'b1;
          o_ctrl = f_alu(o_ctrl, i_opcode);
        end else if (w_addr) begin
          o_ctrl.Cout = 1'b1; o_ctrl.ADD = 1'b1; o_ctrl.Zin = 1'b1;
        end else if (i_opcode == OP_BR) begin
          o_ctrl.PCout = 1'b1; o_ctrl.Yin = 1'b1;
        end else if (i_opcode == OP_JAL) begin
          o_ctrl.Gra = 1'b1; o_ctrl.Rout = 1'b1; o_ctrl.PCin = 1'b1; o_last = 1'b1;
        end else begin
          o_last = 1'b1;
        end
      end
      S_T5: begin
        if (w_rr || w_imm || i_opcode == OP_LDI) begin
          o_ctrl.Zlowout = 1'b1; o_ctrl.Gra = 1'b1; o_ctrl.Rin = 1'b1; o_last = 1'b1;
        end else if (w_muldiv) begin
          o_ctrl.Zlowout = 1'b1; o_ctrl.LOin = 1'b1;
        end else if (i_opcode == OP_LD || i_opcode == OP_ST) begin
          o_ctrl.Zlowout = 1'b1; o_ctrl.MARin = 1'b1;
        end else if (i_opcode == OP_BR) begin
          o_ctrl.Cout = 1'b1; o_ctrl.ADD = 1'b1; o_ctrl.Zin = 1'b1;
        end else begin
          o_last = 1'b1;
        end
      end
      S_T6: begin
        if (w_muldiv) begin
          o_ctrl.Zhighout = 1'b1; o_ctrl.HIin = 1'b1; o_last = 1'b1;
        end else if (i_opcode == OP_LD) begin
          o_ctrl.Read = 1'b1; o_ctrl.read_mem = 1'b1; o_ctrl.MDRin = 1'b1;
        end else if (i_opcode == OP_ST) begin
          o_ctrl.Gra = 1'b1; o_ctrl.Rout = 1'b1; o_ctrl.MDRin = 1'b1;
        end else begin
          // Branch target update is suppressed entirely when the condition failed.
          if (i_opcode == OP_BR && i_con_ff) begin
            o_ctrl.Zlowout = 1'b1; o_ctrl.PCin = 1'b1;
          end
          o_last = 1'b1;
        end
      end
      S_T7: begin
        if (i_opcode == OP_LD) begin
          o_ctrl.MDRout = 1'b1; o_ctrl.Gra = 1'b1; o_ctrl.Rin = 1'b1;
        end else if (i_opcode == OP_ST) begin
          o_ctrl.write_mem = 1'b1;
        end
        o_last = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired control sequencer: state register and step sequencing; strobes come from ctrl_decode.
// Build option CTRL_MULDIV_EN enables the mul/div execute sequences.
module control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int MAX_T = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ir,
  input  logic        con_ff,
  input  logic        stop,
  output logic        run,
  output logic        HIout, LOout, Zhighout, Zlowout, PCout, IRout, MDRout, INout, Cout, Yout, MARout,
  output logic        Read, IncPC,
  output logic        AND, OR, ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT,
  output logic        Gra, Grb, Grc, Rin, Rout, BAout,
  output logic        HIin, LOin, PCin, IRin, Zin, Yin, MARin, MDRin, CONin, OUT_Portin,
  output logic        read_mem, write_mem,
  output logic        CON_RESET, PCSave
);

  localparam logic [2:0] LP_MAX_T = 3'(MAX_T);

  state_t  r_state, w_next;
  opcode_t w_opcode;
  ctrl_t   w_ctrl;
  logic    w_last, w_halt, w_ir_unused;

  assign w_opcode    = ir[31:27];
  assign w_ir_unused = ^ir[26:0];

  ctrl_decode u_decode (
    .i_state  (r_state),
    .i_opcode (w_opcode),
    .i_con_ff (con_ff),
    .o_ctrl   (w_ctrl),
    .o_last   (w_last),
    .o_halt   (w_halt)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RESET: w_next = S_T0;
      S_PAUSE: if (!stop) w_next = S_T0;
      S_HALT:  w_next = S_HALT;
      S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7: begin
        if (w_halt)                                w_next = S_HALT;
        else if (w_last || r_state[2:0] == LP_MAX_T) w_next = stop ? S_PAUSE : S_T0;
        else                                       w_next = state_t'(r_state + 4'd1);
      end
      default: w_next = S_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous here, and state uses non-blocking assignment only.
    if (!reset) r_state <= S_RESET;
    else        r_state <= w_next;
  end

  assign run        = is_step(r_state);
  assign HIout      = w_ctrl.HIout;
  assign LOout      = w_ctrl.LOout;
  assign Zhighout   = w_ctrl.Zhighout;
  assign Zlowout    = w_ctrl.Zlowout;
  assign PCout      = w_ctrl.PCout;
  assign IRout      = w_ctrl.IRout;
  assign MDRout     = w_ctrl.MDRout;
  assign INout      = w_ctrl.INout;
  assign Cout       = w_ctrl.Cout;
  assign Yout       = w_ctrl.Yout;
  assign MARout     = w_ctrl.MARout;
  assign Read       = w_ctrl.Read;
  assign IncPC      = w_ctrl.IncPC;
  assign AND        = w_ctrl.AND;
  assign OR         = w_ctrl.OR;
  assign ADD        = w_ctrl.ADD;
  assign SUB        = w_ctrl.SUB;
  assign MUL        = w_ctrl.MUL;
  assign DIV        = w_ctrl.DIV;
  assign SHR        = w_ctrl.SHR;
  assign SHRA       = w_ctrl.SHRA;
  assign SHL        = w_ctrl.SHL;
  assign ROR        = w_ctrl.ROR;
  assign ROL        = w_ctrl.ROL;
  assign NEG        = w_ctrl.NEG;
  assign NOT        = w_ctrl.NOT;
  assign Gra        = w_ctrl.Gra;
  assign Grb        = w_ctrl.Grb;
  assign Grc        = w_ctrl.Grc;
  assign Rin        = w_ctrl.Rin;
  assign Rout       = w_ctrl.Rout;
  assign BAout      = w_ctrl.BAout;
  assign HIin       = w_ctrl.HIin;
  assign LOin       = w_ctrl.LOin;
  assign PCin       = w_ctrl.PCin;
  assign IRin       = w_ctrl.IRin;
  assign Zin        = w_ctrl.Zin;
  assign Yin        = w_ctrl.Yin;
  assign MARin      = w_ctrl.MARin;
  assign MDRin      = w_ctrl.MDRin;
  assign CONin      = w_ctrl.CONin;
  assign OUT_Portin = w_ctrl.OUT_Portin;
  assign read_mem   = w_ctrl.read_mem;
  assign write_mem  = w_ctrl.write_mem;
  assign CON_RESET  = w_ctrl.CON_RESET;
  assign PCSave     = w_ctrl.PCSave;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: walks fetch/execute of several instructions, pause, halt, reset.
module tb_control_unit;

  localparam logic [31:0] IR_ADD  = 32'h18A0_0000;
  localparam logic [31:0] IR_LD   = 32'h0080_0055;
  localparam logic [31:0] IR_BR   = 32'h9800_0000;
  localparam logic [31:0] IR_JR   = 32'hA000_0000;
  localparam logic [31:0] IR_MUL  = 32'h8000_0000;
  localparam logic [31:0] IR_HALT = 32'hD800_0000;

  logic clk, reset, con_ff, stop, run;
  logic [31:0] ir;
  logic HIout, LOout, Zhighout, Zlowout, PCout, IRout, MDRout, INout, Cout, Yout, MARout;
  logic Read, IncPC;
  logic AND, OR, ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT;
  logic Gra, Grb, Grc, Rin, Rout, BAout;
  logic HIin, LOin, PCin, IRin, Zin, Yin, MARin, MDRin, CONin, OUT_Portin;
  logic read_mem, write_mem, CON_RESET, PCSave;
  logic [45:0] w_all;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  control_unit dut (
    .clk(clk), .reset(reset), .ir(ir), .con_ff(con_ff), .stop(stop), .run(run),
    .HIout(HIout), .LOout(LOout), .Zhighout(Zhighout), .Zlowout(Zlowout), .PCout(PCout),
    .IRout(IRout), .MDRout(MDRout), .INout(INout), .Cout(Cout), .Yout(Yout), .MARout(MARout),
    .Read(Read), .IncPC(IncPC),
    .AND(AND), .OR(OR), .ADD(ADD), .SUB(SUB), .MUL(MUL), .DIV(DIV), .SHR(SHR), .SHRA(SHRA),
    .SHL(SHL), .ROR(ROR), .ROL(ROL), .NEG(NEG), .NOT(NOT),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .HIin(HIin), .LOin(LOin), .PCin(PCin), .IRin(IRin), .Zin(Zin), .Yin(Yin), .MARin(MARin),
    .MDRin(MDRin), .CONin(CONin), .OUT_Portin(OUT_Portin),
    .read_mem(read_mem), .write_mem(write_mem), .CON_RESET(CON_RESET), .PCSave(PCSave)
  );

  assign w_all = {HIout, LOout, Zhighout, Zlowout, PCout, IRout, MDRout, INout, Cout, Yout, MARout,
                  Read, IncPC,
                  AND, OR, ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT,
                  Gra, Grb, Grc, Rin, Rout, BAout,
                  HIin, LOin, PCin, IRin, Zin, Yin, MARin, MDRin, CONin, OUT_Portin,
                  read_mem, write_mem, CON_RESET, PCSave};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] ones();
    return 32'($countones(w_all));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; ir = '0; con_ff = 1'b0; stop = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_con_reset", 32'(CON_RESET), 1);
    check("reset_ones", ones(), 1);
    check("reset_run", 32'(run), 0);

    // add R1,R2,R4: 6 cycles
    reset = 1'b1; ir = IR_ADD;
    tick(); check("t0_strobes", 32'({IncPC, PCin, MARin}), 7);
    check("t0_ones", ones(), 3);
    check("t0_run", 32'(run), 1);
    tick(); check("t1_strobes", 32'({Read, read_mem, MDRin}), 7);
    check("t1_ones", ones(), 3);
    tick(); check("t2_strobes", 32'({Read, read_mem, MDRout, IRin}), 15);
    check("t2_ones", ones(), 4);
    tick(); check("add_t3", 32'({Grb, Rout, Yin}), 7);
    check("add_t3_ones", ones(), 3);
    tick(); check("add_t4", 32'({Grc, Rout, ADD, Zin}), 15);
    check("add_t4_ones", ones(), 4);
    tick(); check("add_t5", 32'({Zlowout, Gra, Rin}), 7);
    check("add_t5_ones", ones(), 3);
    tick(); check("add_back_t0", 32'({IncPC, PCin, MARin}), 7);

    // ld: 8 cycles, read_mem in T1, T2, T6
    ir = IR_LD;
    tick(); check("ld_t1_read", 32'(read_mem), 1);
    tick(); check("ld_t2_read", 32'(read_mem), 1);
    tick(); check("ld_t3", 32'({Grb, BAout, Yin}), 7);
    tick(); check("ld_t4", 32'({Cout, ADD, Zin}), 7);
    tick(); check("ld_t5", 32'({Zlowout, MARin}), 3);
    check("ld_t5_read", 32'(read_mem), 0);
    tick(); check("ld_t6", 32'({Read, read_mem, MDRin}), 7);
    check("ld_t6_ones", ones(), 3);
    tick(); check("ld_t7", 32'({MDRout, Gra, Rin}), 7);
    check("ld_t7_ones", ones(), 3);
    tick(); check("ld_back_t0", 32'({IncPC, PCin, MARin}), 7);

    // br not taken
    ir = IR_BR; con_ff = 1'b0;
    repeat (3) tick();
    check("br_t3", 32'({Gra, Rout, CONin}), 7);
    tick(); check("br_t4", 32'({PCout, Yin}), 3);
    tick(); check("br_t5", 32'({Cout, ADD, Zin}), 7);
    tick(); check("br0_t6_pcin", 32'(PCin), 0);
    check("br0_t6_ones", ones(), 0);
    tick(); check("br0_back_t0", 32'(IncPC), 1);

    // br taken
    con_ff = 1'b1;
    repeat (6) tick();
    check("br1_t6", 32'({Zlowout, PCin}), 3);
    tick(); check("br1_back_t0", 32'(IncPC), 1);
    con_ff = 1'b0;

    // jr: 4 cycles
    ir = IR_JR;
    repeat (3) tick();
    check("jr_t3", 32'({Gra, Rout, PCin}), 7);
    tick(); check("jr_back_t0", 32'({IncPC, MARin}), 3);

    // stop raised mid-add: honoured only after T5
    ir = IR_ADD;
    repeat (4) tick();
    stop = 1'b1;
    tick(); check("stop_t5", 32'({run, Zlowout}), 3);
    tick(); check("pause_run", 32'(run), 0);
    check("pause_ones", ones(), 0);
    tick(); check("pause_hold", 32'(run), 0);
    stop = 1'b0;
    tick(); check("pause_exit_t0", 32'({run, IncPC}), 3);

    // mul compiled out: behaves as nop
    ir = IR_MUL;
    repeat (3) tick();
    check("mul_t3_ones", ones(), 0);
    check("mul_t3_run", 32'(run), 1);
    tick(); check("mul_back_t0", 32'({IncPC, MUL}), 2);

    // reset mid-instruction
    ir = IR_ADD;
    repeat (3) tick();
    reset = 1'b0;
    tick(); check("midreset_con_reset", 32'({run, CON_RESET}), 1);
    reset = 1'b1;
    tick(); check("midreset_t0", 32'(IncPC), 1);

    // halt: idle until reset
    ir = IR_HALT;
    repeat (3) tick();
    check("halt_t3_ones", ones(), 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("halt_idle_%0d", i), ones() + 32'(run), 0);
    end
    reset = 1'b0;
    tick(); check("halt_reset", 32'(CON_RESET), 1);
    check("halt_reset_ones", ones(), 1);
    reset = 1'b1;
    tick(); check("halt_reset_t0", 32'({IncPC, PCin, MARin}), 7);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
